// File: rtl/artec_dma_axi_writer.sv
// -----------------------------------------------------------------------------
// artec_dma_axi_writer
// Downstream stage of the DMA channel buffer. Turns each task (address, beat
// count, eof) into one AXI4 INCR write burst, streams the data beats through
// to the W channel, and tracks outstanding B responses. Completion (frame_done)
// and error status are reported to the register block.
//
// Optional feature: define ARTEC_DMA_WR_ERR_CNT_EN to add err_cnt_o[15:0], a
// saturating count of error B responses, cleared by clear_i.
// -----------------------------------------------------------------------------
module artec_dma_axi_writer #(
    parameter int DW              = 512,
    parameter int AW              = 32,
    parameter int PACKET_SIZE     = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             clear_i,
    // task stream
    input  logic                             task_valid_i,
    output logic                             task_ready_o,
    input  logic [AW-1:0]                    task_addr_i,
    input  logic [$clog2(PACKET_SIZE+1)-1:0] task_num_i,
    input  logic                             task_eof_i,
    // data stream
    input  logic                             data_valid_i,
    output logic                             data_ready_o,
    input  logic [DW-1:0]                    data_i,
    // AXI4 write address channel
    output logic [AW-1:0]                    m_awaddr,
    output logic [7:0]                       m_awlen,
    output logic [2:0]                       m_awsize,
    output logic [1:0]                       m_awburst,
    output logic                             m_awvalid,
    input  logic                             m_awready,
    // AXI4 write data channel
    output logic [DW-1:0]                    m_wdata,
    output logic [DW/8-1:0]                  m_wstrb,
    output logic                             m_wlast,
    output logic                             m_wvalid,
    input  logic                             m_wready,
    // AXI4 write response channel
    input  logic [1:0]                       m_bresp,
    input  logic                             m_bvalid,
    output logic                             m_bready,
    // status
    output logic                             busy_o,
    output logic                             frame_done_o,
`ifdef ARTEC_DMA_WR_ERR_CNT_EN
    output logic [15:0]                      err_cnt_o,
`endif
    output logic                             err_o
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                     state_q, state_d;
    logic [AW-1:0]              awaddr_q, awaddr_d;
    logic [7:0]                 awlen_q, awlen_d;
    logic                       eof_q, eof_d;
    logic                       awvalid_q, awvalid_d;
    logic [7:0]                 beat_q, beat_d;
    logic [OW-1:0]              out_q, out_d;
    logic [MAX_OUTSTANDING-1:0] eof_fifo_q, eof_fifo_d;
    logic                       frame_done_q, frame_done_d;
    logic                       err_q, err_d;
`ifdef ARTEC_DMA_WR_ERR_CNT_EN
    logic [15:0]                err_cnt_q, err_cnt_d;
`endif

    logic          task_hs;
    logic          aw_hs;
    logic          w_hs;
    logic          b_pop;
    logic          b_err;
    logic [OW-1:0] push_idx;

    assign task_hs  = task_valid_i && task_ready_o;
    assign aw_hs    = awvalid_q && m_awready;
    assign w_hs     = m_wvalid && m_wready;
    // A response with nothing outstanding is spurious and dropped entirely.
    assign b_pop    = m_bvalid && (out_q != '0);
    assign b_err    = b_pop && (m_bresp != 2'b00);
    // On a simultaneous pop the FIFO shifts down first, so the new entry lands
    // one slot lower.
    assign push_idx = out_q - OW'(b_pop);

    // Burst sequencing: accept a task, present AW, then count W beats to wlast.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        eof_d     = eof_q;
        awvalid_d = awvalid_q;
        beat_d    = beat_q;
        case (state_q)
            IDLE: begin
                // Zero-beat tasks are consumed here without any AXI traffic.
                if (task_hs && (task_num_i != '0)) begin
                    awaddr_d  = task_addr_i;
                    awlen_d   = 8'(task_num_i) - 8'd1;
                    eof_d     = task_eof_i;
                    awvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    beat_d    = 8'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (m_wlast) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outstanding-burst bookkeeping and status: eof FIFO in issue order.
    always_comb begin
        out_d        = out_q;
        eof_fifo_d   = eof_fifo_q;
        frame_done_d = b_pop && eof_fifo_q[0];
        if (b_pop) begin
            eof_fifo_d = eof_fifo_q >> 1;
        end
        if (aw_hs) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (OW'(i) == push_idx) begin
                    eof_fifo_d[i] = eof_q;
                end
            end
        end
        case ({aw_hs, b_pop})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
        // An error arriving in the same cycle as clear_i is not lost.
        if (b_err) begin
            err_d = 1'b1;
        end else if (clear_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
`ifdef ARTEC_DMA_WR_ERR_CNT_EN
        if (clear_i) begin
            err_cnt_d = b_err ? 16'd1 : 16'd0;
        end else if (b_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
`else
        // Without the counter, error reporting is the sticky err_o flag only.
`endif
    end

    // State register for the FSM, counters, eof FIFO and status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the eof FIFO is a handful of flops, so it is reset along
            // with everything else rather than left undefined.
            state_q      <= IDLE;
            awaddr_q     <= '0;
            awlen_q      <= '0;
            eof_q        <= 1'b0;
            awvalid_q    <= 1'b0;
            beat_q       <= '0;
            out_q        <= '0;
            eof_fifo_q   <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef ARTEC_DMA_WR_ERR_CNT_EN
            err_cnt_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so all flops update together.
            state_q      <= state_d;
            awaddr_q     <= awaddr_d;
            awlen_q      <= awlen_d;
            eof_q        <= eof_d;
            awvalid_q    <= awvalid_d;
            beat_q       <= beat_d;
            out_q        <= out_d;
            eof_fifo_q   <= eof_fifo_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
`ifdef ARTEC_DMA_WR_ERR_CNT_EN
            err_cnt_q    <= err_cnt_d;
`endif
        end
    end

    assign task_ready_o = (state_q == IDLE) && (out_q < MAX_OUT);

    assign m_awaddr     = awaddr_q;
    assign m_awlen      = awlen_q;
    assign m_awsize     = 3'($clog2(DW / 8));
    assign m_awburst    = 2'b01;
    assign m_awvalid    = awvalid_q;

    // Data beats pass straight through; only the handshake is gated by state.
    assign m_wdata      = data_i;
    assign m_wstrb      = '1;
    assign m_wvalid     = (state_q == DATA) && data_valid_i;
    assign data_ready_o = (state_q == DATA) && m_wready;
    assign m_wlast      = (state_q == DATA) && (beat_q == awlen_q);

    assign m_bready     = 1'b1;

    assign busy_o       = (state_q != IDLE) || (out_q != '0);
    assign frame_done_o = frame_done_q;
    assign err_o        = err_q;
`ifdef ARTEC_DMA_WR_ERR_CNT_EN
    assign err_cnt_o    = err_cnt_q;
`endif

endmodule

// File: tb/tb_artec_dma_axi_writer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for artec_dma_axi_writer (default parameters).
// Expected AW fields, W beats and eof flags are queued when a task is accepted
// and popped as the DUT produces AW/W handshakes and B-driven status.
// -----------------------------------------------------------------------------
module tb_artec_dma_axi_writer;

    localparam int DW = 512;
    localparam int AW = 32;
    localparam int PS = 32;
    localparam int MO = 4;
    localparam int NW = $clog2(PS + 1);

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } aw_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } w_exp_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic            clear_i;
    logic            task_valid_i;
    logic            task_ready_o;
    logic [AW-1:0]   task_addr_i;
    logic [NW-1:0]   task_num_i;
    logic            task_eof_i;
    logic            data_valid_i = 1'b0;
    logic            data_ready_o;
    logic [DW-1:0]   data_i = '0;
    logic [AW-1:0]   m_awaddr;
    logic [7:0]      m_awlen;
    logic [2:0]      m_awsize;
    logic [1:0]      m_awburst;
    logic            m_awvalid;
    logic            m_awready;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic            m_wlast;
    logic            m_wvalid;
    logic            m_wready = 1'b1;
    logic [1:0]      m_bresp;
    logic            m_bvalid;
    logic            m_bready;
    logic            busy_o;
    logic            frame_done_o;
    logic            err_o;
`ifdef ARTEC_DMA_WR_ERR_CNT_EN
    logic [15:0]     err_cnt_o;
`endif

    aw_exp_t       exp_aw[$];
    w_exp_t        exp_w[$];
    logic [DW-1:0] data_q[$];
    bit            exp_eof[$];

    int n_tests = 0;
    int n_fail  = 0;
    int aw_cnt  = 0;
    int w_cnt   = 0;
    int wready_mode = 0;   // 0: always ready, 1: toggle 1010...
    bit dv_rand = 1'b0;    // randomise data_valid_i
    bit exp_err = 1'b0;

    always #5 clk = ~clk;

    artec_dma_axi_writer #(
        .DW(DW), .AW(AW), .PACKET_SIZE(PS), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rstn(rstn), .clear_i(clear_i),
        .task_valid_i(task_valid_i), .task_ready_o(task_ready_o),
        .task_addr_i(task_addr_i), .task_num_i(task_num_i), .task_eof_i(task_eof_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .busy_o(busy_o), .frame_done_o(frame_done_o),
`ifdef ARTEC_DMA_WR_ERR_CNT_EN
        .err_cnt_o(err_cnt_o),
`endif
        .err_o(err_o)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Scoreboard: compare every AW and W handshake against the queued expectations.
    always @(negedge clk) begin
        if (rstn) begin
            if (m_awvalid && m_awready) begin
                aw_cnt++;
                if (exp_aw.size() == 0) begin
                    check("aw_unexpected", 1, 0);
                end else begin
                    aw_exp_t e;
                    e = exp_aw.pop_front();
                    check("awaddr", m_awaddr, e.addr);
                    check("awlen", m_awlen, e.len);
                end
            end
            if (m_wvalid && m_wready) begin
                w_cnt++;
                if (exp_w.size() == 0) begin
                    check("w_unexpected", 1, 0);
                end else begin
                    w_exp_t e;
                    e = exp_w.pop_front();
                    check("wdata", m_wdata, e.data);
                    check("wlast", m_wlast, e.last);
                end
            end
        end
    end

    // Data source and W-ready pattern generator.
    always begin
        bit hs;
        @(negedge clk);
        hs = data_valid_i && data_ready_o;
        @(posedge clk);
        #1;
        if (hs && data_q.size() > 0) void'(data_q.pop_front());
        if (wready_mode == 1) m_wready = ~m_wready;
        else                  m_wready = 1'b1;
        data_valid_i = (data_q.size() > 0) && (dv_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
        data_i       = (data_q.size() > 0) ? data_q[0] : '0;
    end

    task automatic drive_task(input logic [AW-1:0] addr, input int num, input bit eof);
        task_addr_i  = addr;
        task_num_i   = NW'(num);
        task_eof_i   = eof;
        task_valid_i = 1'b1;
    endtask

    // Wait (bounded) for the pending task to be accepted; queue its expectations.
    task automatic wait_task(input int budget, output bit ok);
        int n;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (task_valid_i && task_ready_o) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
            task_valid_i = 1'b0;
            n = int'(task_num_i);
            if (n != 0) begin
                aw_exp_t a;
                a.addr = task_addr_i;
                a.len  = 8'(n - 1);
                exp_aw.push_back(a);
                for (int b = 0; b < n; b++) begin
                    w_exp_t w;
                    w.data = rand_beat();
                    w.last = (b == n - 1);
                    data_q.push_back(w.data);
                    exp_w.push_back(w);
                end
                exp_eof.push_back(task_eof_i);
            end
        end
    endtask

    task automatic send_task(input logic [AW-1:0] addr, input int num, input bit eof);
        bit ok;
        drive_task(addr, num, eof);
        wait_task(200, ok);
        check("task_accept", ok, 1);
    endtask

    task automatic wait_w(input int target);
        for (int i = 0; i < 1000 && w_cnt < target; i++) begin
            @(posedge clk);
            #2;
        end
        check("w_count", w_cnt, target);
    endtask

    task automatic wait_aw(input int target);
        for (int i = 0; i < 200 && aw_cnt < target; i++) begin
            @(posedge clk);
            #2;
        end
        check("aw_count", aw_cnt, target);
    endtask

    // One-cycle B response; optionally raise awready in the same cycle.
    task automatic send_b(input logic [1:0] resp, input bit with_aw);
        bit e;
        @(posedge clk);
        #1;
        m_bvalid = 1'b1;
        m_bresp  = resp;
        if (with_aw) m_awready = 1'b1;
        @(posedge clk);
        #1;
        m_bvalid = 1'b0;
        m_bresp  = 2'b00;
        e = (exp_eof.size() > 0) ? exp_eof.pop_front() : 1'b0;
        if (resp != 2'b00) exp_err = 1'b1;
        check("frame_done", frame_done_o, e);
        check("err_o", err_o, exp_err);
    endtask

    initial begin
        bit ok;
        int aw0, w0;
        rstn         = 1'b0;
        clear_i      = 1'b0;
        task_valid_i = 1'b0;
        task_addr_i  = '0;
        task_num_i   = '0;
        task_eof_i   = 1'b0;
        m_awready    = 1'b1;
        m_bvalid     = 1'b0;
        m_bresp      = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #2;

        // Reset state and constant AXI fields
        check("rst_task_ready", task_ready_o, 1);
        check("rst_awvalid", m_awvalid, 0);
        check("rst_wvalid", m_wvalid, 0);
        check("rst_data_ready", data_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        check("rst_frame_done", frame_done_o, 0);
        check("rst_awaddr", m_awaddr, 0);
        check("rst_awlen", m_awlen, 0);
        check("awsize", m_awsize, 6);
        check("awburst", m_awburst, 1);
        check("wstrb", m_wstrb, {(DW/8){1'b1}});
        check("bready", m_bready, 1);
`ifdef ARTEC_DMA_WR_ERR_CNT_EN
        check("rst_err_cnt", err_cnt_o, 0);
`endif

        // Single 32-beat burst, everything always ready
        aw0 = aw_cnt;
        w0  = w_cnt;
        send_task(32'h1000_0000, 32, 1'b0);
        wait_w(w0 + 32);
        check("single_aw_count", aw_cnt, aw0 + 1);
        check("single_busy_pre_b", busy_o, 1);
        send_b(2'b00, 1'b0);
        check("single_busy_post_b", busy_o, 0);

        // Zero-length task: consumed, no AXI traffic, never busy
        aw0 = aw_cnt;
        w0  = w_cnt;
        drive_task(32'h2000_0000, 0, 1'b0);
        wait_task(20, ok);
        check("zero_accept", ok, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            check("zero_busy", busy_o, 0);
        end
        check("zero_aw", aw_cnt, aw0);
        check("zero_w", w_cnt, w0);

        // Outstanding limit: B held off, 4 bursts then task_ready_o low
        aw0 = aw_cnt;
        w0  = w_cnt;
        for (int i = 0; i < 4; i++) send_task(32'h3000_0000 + 32'(i * 256), 4, 1'b0);
        wait_w(w0 + 16);
        check("limit_aw4", aw_cnt, aw0 + 4);
        check("limit_ready_low", task_ready_o, 0);
        drive_task(32'h3000_0400, 4, 1'b0);
        wait_task(10, ok);
        check("limit_blocked", ok, 0);
        check("limit_aw_still4", aw_cnt, aw0 + 4);
        send_b(2'b00, 1'b0);
        wait_task(200, ok);
        check("limit_5th_accept", ok, 1);
        wait_aw(aw0 + 5);
        wait_w(w0 + 20);
        drive_task(32'h3000_0500, 4, 1'b0);
        wait_task(10, ok);
        check("limit_6th_blocked", ok, 0);
        send_b(2'b00, 1'b0);
        wait_task(200, ok);
        check("limit_6th_accept", ok, 1);
        wait_w(w0 + 24);
        for (int i = 0; i < 4; i++) send_b(2'b00, 1'b0);
        check("limit_drained_busy", busy_o, 0);

        // Back-pressure: toggling wready, random data_valid, 8 beats
        w0 = w_cnt;
        wready_mode = 1;
        dv_rand     = 1'b1;
        send_task(32'h4000_0000, 8, 1'b0);
        wait_w(w0 + 8);
        wready_mode = 0;
        dv_rand     = 1'b0;
        send_b(2'b00, 1'b0);
        check("bp_data_drained", data_q.size(), 0);

        // EOF and error: middle task closes a frame and gets SLVERR
        w0 = w_cnt;
        send_task(32'h5000_0000, 2, 1'b0);
        send_task(32'h5000_0100, 2, 1'b1);
        send_task(32'h5000_0200, 2, 1'b0);
        wait_w(w0 + 6);
        send_b(2'b00, 1'b0);
        send_b(2'b10, 1'b0);
        @(posedge clk);
        #1;
        check("eof_pulse_once", frame_done_o, 0);
        send_b(2'b00, 1'b0);
`ifdef ARTEC_DMA_WR_ERR_CNT_EN
        check("err_cnt_one", err_cnt_o, 1);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", err_o, 1);
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        exp_err = 1'b0;
        check("err_cleared", err_o, 0);
`ifdef ARTEC_DMA_WR_ERR_CNT_EN
        check("err_cnt_cleared", err_cnt_o, 0);
`endif

        // Simultaneous AW handshake and B response at outstanding = 2
        w0 = w_cnt;
        send_task(32'h6000_0000, 2, 1'b0);
        send_task(32'h6000_0100, 2, 1'b1);
        wait_w(w0 + 4);
        m_awready = 1'b0;
        send_task(32'h6000_0200, 2, 1'b0);
        send_b(2'b00, 1'b1);
        wait_w(w0 + 6);
        send_task(32'h6000_0300, 2, 1'b0);
        send_task(32'h6000_0400, 2, 1'b0);
        wait_w(w0 + 10);
        check("simul_full", task_ready_o, 0);
        for (int i = 0; i < 4; i++) send_b(2'b00, 1'b0);
        check("simul_idle", busy_o, 0);
        check("simul_aw_left", exp_aw.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
